add_sub_rs: RTL and testbench
=============================

ADD_SUB_RS -- requirements
Module: add_sub_rs

Interface
REQ-001 The module SHALL have parameter ENTRIES, default 4, giving the number of reservation-station entries (2..8).
REQ-002 The module SHALL have parameter TAG_WIDTH, default 5, giving the width of the producer tag.
REQ-003 The module SHALL have parameter RS_ID_WIDTH, default 5, giving the width of the issue ID (at least clog2(ENTRIES)).
REQ-004 Port clk, input, 1: clock; all state SHALL update on the rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port disp_valid, input, 1: dispatch request.
REQ-007 Port disp_ready, output, 1: station can accept a dispatch.
REQ-008 Port disp_result_reg_addr, input, 5: destination GPR.
REQ-009 Port disp_control, input, add_sub_decode_t: operation decode.
REQ-010 Ports disp_op1 and disp_op2, input, 32 each: operand values.
REQ-011 Ports disp_op1_valid and disp_op2_valid, input, 1 each: operand value present.
REQ-012 Ports disp_op1_tag and disp_op2_tag, input, TAG_WIDTH each: producer tag, meaningful only when the operand is not valid.
REQ-013 Ports disp_ca, disp_ca_valid (input, 1 each) and disp_ca_tag (input, TAG_WIDTH): carry operand with the same rules as REQ-011/REQ-012.
REQ-014 Ports cdb_valid (input, 1), cdb_tag (input, TAG_WIDTH), cdb_data (input, 32) and cdb_ca (input, 1): result broadcast bus.
REQ-015 Port issue_valid, output, 1: issue register holds an operation.
REQ-016 Port issue_ready, input, 1: execution unit accepts the issue.
REQ-017 Port issue_rs_id, output, RS_ID_WIDTH: index of the source entry, zero-extended.
REQ-018 Port issue_result_reg_addr, output, 5: destination GPR of the issued operation.
REQ-019 Ports issue_op1 and issue_op2, output, 32 each: operand values.
REQ-020 Port issue_carry_in, output, 1: carry operand.
REQ-021 Port issue_control, output, add_sub_decode_t: operation decode.
REQ-022 Port count, output, clog2(ENTRIES+1): number of occupied entries.

Function
REQ-023 Each entry SHALL hold: busy bit, result_reg_addr, control, and for each of op1, op2 and ca a value, a valid bit and a tag.
REQ-024 disp_ready SHALL equal (count < ENTRIES), computed from registered state only.
- A free slot created by an issue in the same cycle SHALL NOT be visible until the next cycle.
REQ-025 When disp_valid and disp_ready are both high, the lowest-index free entry SHALL be written and marked busy at the clock edge.
REQ-026 Same-cycle bypass at dispatch: an operand arriving not valid SHALL be stored as valid with cdb_data (or cdb_ca for the carry) when cdb_valid is high and cdb_tag equals its tag.
REQ-027 Wakeup: every busy entry with an operand not valid and tag equal to cdb_tag, while cdb_valid is high, SHALL capture cdb_data or cdb_ca and set that operand valid at the next edge.
REQ-028 An entry SHALL be ready when it is busy and all three operand valid bits are set, evaluated on registered state.
REQ-029 Age ordering SHALL be kept by an ENTRIES x ENTRIES age matrix.
- A newly written entry SHALL be younger than all busy entries.
- The selector SHALL pick the oldest ready entry.
REQ-030 The issue output register SHALL load when it is empty or issue_ready is high.
- If a ready entry exists, the oldest ready entry SHALL be loaded, issue_valid set, and the entry freed in the same edge.
- Otherwise issue_valid SHALL clear.
REQ-031 Issue handshake: issue outputs SHALL stay stable while issue_valid is high and issue_ready is low.
REQ-032 Minimum latency: a dispatch at edge t with all operands valid SHALL give issue_valid high after edge t+1.
- A CDB wakeup captured at edge t SHALL make the entry eligible for issue at edge t+1.
REQ-033 count SHALL increment on dispatch and decrement on issue-free; simultaneous dispatch and free SHALL leave count unchanged.
REQ-034 On issue_valid with issue_ready the operation is consumed; there is no replay.

Reset
REQ-035 While rst is high at an edge, all busy bits, valid bits and the age matrix SHALL clear.
REQ-036 While rst is high at an edge, issue_valid SHALL be 0, count 0, and all issue data outputs 0.
REQ-037 disp_ready SHALL be 1 in the cycle after reset.
REQ-038 Reset SHALL discard in-flight entries regardless of handshake state.

Verification
REQ-039 Dispatch op1=5, op2=7, ca=0, all valid, issue_ready=1 -> issue_valid after 2 edges with issue_op1=5, issue_op2=7, issue_rs_id=0; count goes 1 then 0.
REQ-040 Dispatch with op1 tag 3 not valid; 4 cycles later cdb_valid=1, cdb_tag=3, cdb_data=0x1234 -> issue 2 edges later with issue_op1=0x1234.
REQ-041 Dispatch A (waiting on tag 2), then B (all valid), then C (all valid); broadcast tag 2 -> issue order B, C, A.
REQ-042 Fill 4 entries with issue_ready=0 -> disp_ready=0 and count=4; issue outputs stay stable; one accept -> disp_ready=1 on the next cycle only.
REQ-043 cdb_tag equals a dispatching operand's tag in the same cycle -> the value is captured and issue occurs 2 edges later.
REQ-044 Assert rst with 3 busy entries and issue_valid=1 -> next cycle count=0, issue_valid=0, disp_ready=1.

Source files
------------

// File: rtl/add_sub_rs.sv
// add_sub_rs: reservation station for the add/subtract execution unit.
//
// Holds up to ENTRIES dispatched operations until op1, op2 and the carry
// operand are all present, snooping the CDB for missing values, then issues
// the oldest ready operation through a single registered issue stage.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   disp_*                    dispatch request, operands with valid/tag, decode
//   disp_ready                a free entry exists (registered state only)
//   cdb_valid/tag/data/ca     result broadcast bus
//   issue_valid/issue_ready   issue handshake
//   issue_rs_id               source entry index, zero-extended
//   issue_result_reg_addr     destination GPR
//   issue_op1/op2/carry_in    operand values
//   issue_control             operation decode
//   count                     occupied entries

package add_sub_pkg;
   typedef struct packed {
      logic subtract;
      logic use_carry;
      logic invert_carry;
   } add_sub_decode_t;
endpackage

module add_sub_rs
   import add_sub_pkg::*;
#(
   parameter int ENTRIES     = 4,
   parameter int TAG_WIDTH   = 5,
   parameter int RS_ID_WIDTH = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       disp_valid,
   output logic                       disp_ready,
   input  logic [4:0]                 disp_result_reg_addr,
   input  add_sub_decode_t            disp_control,
   input  logic [31:0]                disp_op1,
   input  logic [31:0]                disp_op2,
   input  logic                       disp_op1_valid,
   input  logic                       disp_op2_valid,
   input  logic [TAG_WIDTH-1:0]       disp_op1_tag,
   input  logic [TAG_WIDTH-1:0]       disp_op2_tag,
   input  logic                       disp_ca,
   input  logic                       disp_ca_valid,
   input  logic [TAG_WIDTH-1:0]       disp_ca_tag,
   input  logic                       cdb_valid,
   input  logic [TAG_WIDTH-1:0]       cdb_tag,
   input  logic [31:0]                cdb_data,
   input  logic                       cdb_ca,
   output logic                       issue_valid,
   input  logic                       issue_ready,
   output logic [RS_ID_WIDTH-1:0]     issue_rs_id,
   output logic [4:0]                 issue_result_reg_addr,
   output logic [31:0]                issue_op1,
   output logic [31:0]                issue_op2,
   output logic                       issue_carry_in,
   output add_sub_decode_t            issue_control,
   output logic [$clog2(ENTRIES+1)-1:0] count
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int CNT_W = $clog2(ENTRIES+1);

   // Entry storage
   logic [ENTRIES-1:0]   busy;
   logic [ENTRIES-1:0]   op1_v;
   logic [ENTRIES-1:0]   op2_v;
   logic [ENTRIES-1:0]   ca_v;
   logic [4:0]           rd_q     [ENTRIES];
   add_sub_decode_t      ctrl_q   [ENTRIES];
   logic [31:0]          op1_q    [ENTRIES];
   logic [31:0]          op2_q    [ENTRIES];
   logic                 ca_q     [ENTRIES];
   logic [TAG_WIDTH-1:0] op1_tag_q[ENTRIES];
   logic [TAG_WIDTH-1:0] op2_tag_q[ENTRIES];
   logic [TAG_WIDTH-1:0] ca_tag_q [ENTRIES];

   // older[i][j] set: entry i was written before entry j
   logic [ENTRIES-1:0]   older    [ENTRIES];

   logic [CNT_W-1:0]     count_q;

   logic [ENTRIES-1:0]   ready;
   logic [ENTRIES-1:0]   sel_vec;
   logic [IDX_W-1:0]     sel_idx;
   logic [IDX_W-1:0]     free_idx;
   logic                 free_found;
   logic                 any_ready;
   logic                 do_disp;
   logic                 load;
   logic                 do_issue;

   // Dispatch operands after same-cycle CDB bypass
   logic                 d_op1_v;
   logic                 d_op2_v;
   logic                 d_ca_v;
   logic [31:0]          d_op1;
   logic [31:0]          d_op2;
   logic                 d_ca;

   assign disp_ready = (count_q < CNT_W'(ENTRIES));
   assign count      = count_q;
   assign ready      = busy & op1_v & op2_v & ca_v;
   assign any_ready  = |ready;
   assign do_disp    = disp_valid && disp_ready;
   assign load       = !issue_valid || issue_ready;
   assign do_issue   = load && any_ready;

   assign d_op1_v = disp_op1_valid || (cdb_valid && (cdb_tag == disp_op1_tag));
   assign d_op2_v = disp_op2_valid || (cdb_valid && (cdb_tag == disp_op2_tag));
   assign d_ca_v  = disp_ca_valid  || (cdb_valid && (cdb_tag == disp_ca_tag));
   assign d_op1   = disp_op1_valid ? disp_op1 : cdb_data;
   assign d_op2   = disp_op2_valid ? disp_op2 : cdb_data;
   assign d_ca    = disp_ca_valid  ? disp_ca  : cdb_ca;

   // An entry is selected when no other ready entry is older; the age
   // matrix is a total order over busy entries so at most one bit is set.
   always_comb begin
      sel_vec = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         logic blocked;
         blocked = 1'b0;
         for (int unsigned j = 0; j < ENTRIES; j++) begin
            if (ready[j] && older[j][i]) blocked = 1'b1;
         end
         sel_vec[i] = ready[i] && !blocked;
      end
   end

   always_comb begin
      sel_idx    = '0;
      free_idx   = '0;
      free_found = 1'b0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         if (sel_vec[i]) sel_idx = IDX_W'(i);
      end
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         if (!busy[i] && !free_found) begin
            free_idx   = IDX_W'(i);
            free_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy                  <= '0;
         op1_v                 <= '0;
         op2_v                 <= '0;
         ca_v                  <= '0;
         for (int unsigned i = 0; i < ENTRIES; i++) older[i] <= '0;
         count_q               <= '0;
         issue_valid           <= 1'b0;
         issue_rs_id           <= '0;
         issue_result_reg_addr <= '0;
         issue_op1             <= '0;
         issue_op2             <= '0;
         issue_carry_in        <= 1'b0;
         issue_control         <= '0;
      end else begin
         // Wakeup only touches busy entries, so it never collides with the
         // dispatch write (which targets a non-busy slot).
         if (cdb_valid) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
               if (busy[i] && !op1_v[i] && (op1_tag_q[i] == cdb_tag)) begin
                  op1_q[i] <= cdb_data;
                  op1_v[i] <= 1'b1;
               end
               if (busy[i] && !op2_v[i] && (op2_tag_q[i] == cdb_tag)) begin
                  op2_q[i] <= cdb_data;
                  op2_v[i] <= 1'b1;
               end
               if (busy[i] && !ca_v[i] && (ca_tag_q[i] == cdb_tag)) begin
                  ca_q[i] <= cdb_ca;
                  ca_v[i] <= 1'b1;
               end
            end
         end

         if (do_issue) begin
            busy[sel_idx]         <= 1'b0;
            issue_valid           <= 1'b1;
            issue_rs_id           <= RS_ID_WIDTH'(sel_idx);
            issue_result_reg_addr <= rd_q[sel_idx];
            issue_op1             <= op1_q[sel_idx];
            issue_op2             <= op2_q[sel_idx];
            issue_carry_in        <= ca_q[sel_idx];
            issue_control         <= ctrl_q[sel_idx];
         end else if (load) begin
            issue_valid           <= 1'b0;
         end

         if (do_disp) begin
            busy[free_idx]      <= 1'b1;
            rd_q[free_idx]      <= disp_result_reg_addr;
            ctrl_q[free_idx]    <= disp_control;
            op1_q[free_idx]     <= d_op1;
            op2_q[free_idx]     <= d_op2;
            ca_q[free_idx]      <= d_ca;
            op1_v[free_idx]     <= d_op1_v;
            op2_v[free_idx]     <= d_op2_v;
            ca_v[free_idx]      <= d_ca_v;
            op1_tag_q[free_idx] <= disp_op1_tag;
            op2_tag_q[free_idx] <= disp_op2_tag;
            ca_tag_q[free_idx]  <= disp_ca_tag;
            // New entry is older than nobody and younger than every busy one.
            // busy[free_idx] is 0, so the diagonal bit stays clear.
            older[free_idx]     <= '0;
            for (int unsigned j = 0; j < ENTRIES; j++) begin
               older[j][free_idx] <= busy[j];
            end
         end

         count_q <= count_q + CNT_W'(do_disp) - CNT_W'(do_issue);
      end
   end

endmodule

// File: tb/tb_add_sub_rs.sv
module tb_add_sub_rs;
   import add_sub_pkg::*;

   localparam int ENTRIES = 4;
   localparam int TW      = 5;
   localparam int RW      = 5;

   logic                 clk;
   logic                 rst;
   logic                 disp_valid;
   logic                 disp_ready;
   logic [4:0]           disp_result_reg_addr;
   add_sub_decode_t      disp_control;
   logic [31:0]          disp_op1, disp_op2;
   logic                 disp_op1_valid, disp_op2_valid;
   logic [TW-1:0]        disp_op1_tag, disp_op2_tag;
   logic                 disp_ca, disp_ca_valid;
   logic [TW-1:0]        disp_ca_tag;
   logic                 cdb_valid;
   logic [TW-1:0]        cdb_tag;
   logic [31:0]          cdb_data;
   logic                 cdb_ca;
   logic                 issue_valid;
   logic                 issue_ready;
   logic [RW-1:0]        issue_rs_id;
   logic [4:0]           issue_result_reg_addr;
   logic [31:0]          issue_op1, issue_op2;
   logic                 issue_carry_in;
   add_sub_decode_t      issue_control;
   logic [2:0]           count;

   add_sub_rs #(.ENTRIES(ENTRIES), .TAG_WIDTH(TW), .RS_ID_WIDTH(RW)) dut (
      .clk(clk), .rst(rst),
      .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_result_reg_addr(disp_result_reg_addr), .disp_control(disp_control),
      .disp_op1(disp_op1), .disp_op2(disp_op2),
      .disp_op1_valid(disp_op1_valid), .disp_op2_valid(disp_op2_valid),
      .disp_op1_tag(disp_op1_tag), .disp_op2_tag(disp_op2_tag),
      .disp_ca(disp_ca), .disp_ca_valid(disp_ca_valid), .disp_ca_tag(disp_ca_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_ca(cdb_ca),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rs_id(issue_rs_id),
      .issue_result_reg_addr(issue_result_reg_addr),
      .issue_op1(issue_op1), .issue_op2(issue_op2),
      .issue_carry_in(issue_carry_in), .issue_control(issue_control),
      .count(count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: a list of waiting operations kept oldest-first.
   typedef struct {
      int               slot;
      logic [4:0]       rd;
      add_sub_decode_t  ctrl;
      logic [31:0]      v1, v2;
      logic             c;
      bit               ok1, ok2, okc;
      logic [TW-1:0]    t1, t2, tc;
   } ent_t;

   ent_t            q[$];
   bit              m_iv;
   int              m_id;
   logic [4:0]      m_rd;
   logic [31:0]     m_op1, m_op2;
   logic            m_ca;
   add_sub_decode_t m_ctrl;

   task automatic model_step();
      int   slot;
      int   idx;
      ent_t e;
      bit   used[ENTRIES];
      if (rst) begin
         q.delete();
         m_iv = 0; m_id = 0; m_rd = '0; m_op1 = '0; m_op2 = '0; m_ca = 0; m_ctrl = '0;
         return;
      end
      slot = -1;
      if (disp_valid && (q.size() < ENTRIES)) begin
         foreach (used[s]) used[s] = 0;
         foreach (q[i]) used[q[i].slot] = 1;
         for (int s = ENTRIES - 1; s >= 0; s--) if (!used[s]) slot = s;
      end
      if (!m_iv || issue_ready) begin
         idx = -1;
         foreach (q[i]) if (idx < 0 && q[i].ok1 && q[i].ok2 && q[i].okc) idx = i;
         if (idx >= 0) begin
            m_iv = 1; m_id = q[idx].slot; m_rd = q[idx].rd; m_ctrl = q[idx].ctrl;
            m_op1 = q[idx].v1; m_op2 = q[idx].v2; m_ca = q[idx].c;
            q.delete(idx);
         end else begin
            m_iv = 0;
         end
      end
      if (cdb_valid) begin
         foreach (q[i]) begin
            if (!q[i].ok1 && q[i].t1 == cdb_tag) begin q[i].v1 = cdb_data; q[i].ok1 = 1; end
            if (!q[i].ok2 && q[i].t2 == cdb_tag) begin q[i].v2 = cdb_data; q[i].ok2 = 1; end
            if (!q[i].okc && q[i].tc == cdb_tag) begin q[i].c  = cdb_ca;   q[i].okc = 1; end
         end
      end
      if (slot >= 0) begin
         e.slot = slot; e.rd = disp_result_reg_addr; e.ctrl = disp_control;
         e.t1 = disp_op1_tag; e.t2 = disp_op2_tag; e.tc = disp_ca_tag;
         e.ok1 = disp_op1_valid || (cdb_valid && cdb_tag == disp_op1_tag);
         e.ok2 = disp_op2_valid || (cdb_valid && cdb_tag == disp_op2_tag);
         e.okc = disp_ca_valid  || (cdb_valid && cdb_tag == disp_ca_tag);
         e.v1  = disp_op1_valid ? disp_op1 : cdb_data;
         e.v2  = disp_op2_valid ? disp_op2 : cdb_data;
         e.c   = disp_ca_valid  ? disp_ca  : cdb_ca;
         q.push_back(e);
      end
   endtask

   // Advance one clock with the currently driven inputs; sample point is #1 after the edge.
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      disp_valid = 0; disp_result_reg_addr = '0; disp_control = '0;
      disp_op1 = '0; disp_op2 = '0; disp_op1_valid = 1; disp_op2_valid = 1;
      disp_op1_tag = '0; disp_op2_tag = '0; disp_ca = 0; disp_ca_valid = 1; disp_ca_tag = '0;
      cdb_valid = 0; cdb_tag = '0; cdb_data = '0; cdb_ca = 0;
   endtask

   task automatic disp_all_valid(input logic [31:0] a, input logic [31:0] b);
      disp_valid = 1; disp_op1 = a; disp_op2 = b; disp_ca = 0;
      disp_op1_valid = 1; disp_op2_valid = 1; disp_ca_valid = 1;
   endtask

   task automatic do_reset();
      set_idle();
      rst = 1;
      cycle();
      cycle();
      rst = 0;
   endtask

   task automatic test_reset();
      set_idle();
      issue_ready = 1;
      rst = 1;
      cycle();
      cycle();
      n_checks++;
      if ({issue_valid, count} !== 4'b0)
         $display("FAIL reset_state: issue_valid=%0b count=%0d, expected 0/0", issue_valid, count);
      else n_pass++;
      n_checks++;
      if ({issue_rs_id, issue_result_reg_addr, issue_op1, issue_op2, issue_carry_in, issue_control} !== '0)
         $display("FAIL reset_data: op1=%h op2=%h rs_id=%0d, expected all zero", issue_op1, issue_op2, issue_rs_id);
      else n_pass++;
      rst = 0;
      cycle();
      n_checks++;
      if (disp_ready !== 1'b1)
         $display("FAIL reset_disp_ready: got %0b, expected 1", disp_ready);
      else n_pass++;
   endtask

   task automatic test_basic();
      do_reset();
      issue_ready = 1;
      disp_all_valid(32'd5, 32'd7);
      cycle();
      set_idle();
      n_checks++;
      if (count !== 3'd1 || issue_valid !== 1'b0)
         $display("FAIL basic_edge1: count=%0d issue_valid=%0b, expected 1/0", count, issue_valid);
      else n_pass++;
      cycle();
      n_checks++;
      if (issue_valid !== 1'b1 || issue_op1 !== 32'd5 || issue_op2 !== 32'd7 || issue_rs_id !== 5'd0 || count !== 3'd0)
         $display("FAIL basic_issue: v=%0b op1=%0d op2=%0d id=%0d count=%0d, expected 1/5/7/0/0",
                  issue_valid, issue_op1, issue_op2, issue_rs_id, count);
      else n_pass++;
   endtask

   task automatic test_wakeup();
      do_reset();
      issue_ready = 1;
      disp_all_valid(32'd0, 32'd9);
      disp_op1_valid = 0; disp_op1_tag = 5'd3;
      cycle();
      set_idle();
      for (int k = 0; k < 4; k++) cycle();
      n_checks++;
      if (issue_valid !== 1'b0 || count !== 3'd1)
         $display("FAIL wakeup_wait: issue_valid=%0b count=%0d, expected 0/1", issue_valid, count);
      else n_pass++;
      cdb_valid = 1; cdb_tag = 5'd3; cdb_data = 32'h1234;
      cycle();
      set_idle();
      n_checks++;
      if (issue_valid !== 1'b0)
         $display("FAIL wakeup_early: issue_valid=%0b, expected 0", issue_valid);
      else n_pass++;
      cycle();
      n_checks++;
      if (issue_valid !== 1'b1 || issue_op1 !== 32'h1234 || issue_op2 !== 32'd9)
         $display("FAIL wakeup_issue: v=%0b op1=%h op2=%0d, expected 1/1234/9", issue_valid, issue_op1, issue_op2);
      else n_pass++;
   endtask

   task automatic test_order();
      logic [31:0] seen[$];
      do_reset();
      issue_ready = 1;
      disp_all_valid(32'd1, 32'hA);
      disp_op1_valid = 0; disp_op1_tag = 5'd2;
      cycle();
      set_idle();
      disp_all_valid(32'd1, 32'hB);
      cycle();
      set_idle();
      disp_all_valid(32'd1, 32'hC);
      if (issue_valid) seen.push_back(issue_op2);
      cycle();
      set_idle();
      cdb_valid = 1; cdb_tag = 5'd2; cdb_data = 32'd1;
      if (issue_valid) seen.push_back(issue_op2);
      cycle();
      set_idle();
      for (int k = 0; k < 10 && seen.size() < 3; k++) begin
         if (issue_valid) seen.push_back(issue_op2);
         cycle();
      end
      n_checks++;
      if (seen.size() != 3)
         $display("FAIL order_count: issued %0d ops, expected 3", seen.size());
      else if (seen[0] !== 32'hB || seen[1] !== 32'hC || seen[2] !== 32'hA)
         $display("FAIL order_seq: got %h,%h,%h expected b,c,a", seen[0], seen[1], seen[2]);
      else n_pass++;
   endtask

   task automatic test_full();
      int n;
      do_reset();
      issue_ready = 0;
      n = 0;
      for (int k = 0; k < 8 && disp_ready; k++) begin
         disp_all_valid(32'h100 + 32'(k), 32'd0);
         cycle();
         n++;
      end
      set_idle();
      n_checks++;
      if (count !== 3'd4 || disp_ready !== 1'b0 || n != 5)
         $display("FAIL full_state: count=%0d disp_ready=%0b dispatches=%0d, expected 4/0/5", count, disp_ready, n);
      else n_pass++;
      for (int k = 0; k < 3; k++) cycle();
      n_checks++;
      if (issue_valid !== 1'b1 || issue_op1 !== 32'h100 || issue_rs_id !== 5'd0)
         $display("FAIL full_stable: v=%0b op1=%h id=%0d, expected 1/100/0", issue_valid, issue_op1, issue_rs_id);
      else n_pass++;
      issue_ready = 1;
      #1;
      n_checks++;
      if (disp_ready !== 1'b0)
         $display("FAIL full_same_cycle: disp_ready=%0b, expected 0", disp_ready);
      else n_pass++;
      cycle();
      issue_ready = 0;
      n_checks++;
      if (disp_ready !== 1'b1 || count !== 3'd3 || issue_op1 !== 32'h101)
         $display("FAIL full_accept: disp_ready=%0b count=%0d op1=%h, expected 1/3/101", disp_ready, count, issue_op1);
      else n_pass++;
   endtask

   task automatic test_bypass();
      do_reset();
      issue_ready = 1;
      disp_all_valid(32'd0, 32'd4);
      disp_op1_valid = 0; disp_op1_tag = 5'd6;
      cdb_valid = 1; cdb_tag = 5'd6; cdb_data = 32'hBEEF;
      cycle();
      set_idle();
      n_checks++;
      if (count !== 3'd1 || issue_valid !== 1'b0)
         $display("FAIL bypass_edge1: count=%0d v=%0b, expected 1/0", count, issue_valid);
      else n_pass++;
      cycle();
      n_checks++;
      if (issue_valid !== 1'b1 || issue_op1 !== 32'hBEEF)
         $display("FAIL bypass_issue: v=%0b op1=%h, expected 1/beef", issue_valid, issue_op1);
      else n_pass++;
   endtask

   task automatic test_reset_inflight();
      do_reset();
      issue_ready = 0;
      for (int k = 0; k < 4; k++) begin
         disp_all_valid(32'h200 + 32'(k), 32'd1);
         cycle();
      end
      set_idle();
      cycle();
      n_checks++;
      if (issue_valid !== 1'b1 || count !== 3'd3)
         $display("FAIL inflight_pre: v=%0b count=%0d, expected 1/3", issue_valid, count);
      else n_pass++;
      rst = 1;
      cycle();
      rst = 0;
      n_checks++;
      if (count !== 3'd0 || issue_valid !== 1'b0 || disp_ready !== 1'b1 || issue_op1 !== 32'd0)
         $display("FAIL inflight_reset: count=%0d v=%0b disp_ready=%0b op1=%h, expected 0/0/1/0",
                  count, issue_valid, disp_ready, issue_op1);
      else n_pass++;
   endtask

   task automatic test_random();
      int errs;
      do_reset();
      errs = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         rst            = ($urandom_range(59) == 0);
         disp_valid     = ($urandom_range(1) == 0);
         disp_result_reg_addr = 5'($urandom_range(31));
         disp_control   = add_sub_decode_t'(3'($urandom_range(7)));
         disp_op1       = $urandom;
         disp_op2       = $urandom;
         disp_ca        = 1'($urandom_range(1));
         disp_op1_valid = ($urandom_range(4) < 3);
         disp_op2_valid = ($urandom_range(4) < 3);
         disp_ca_valid  = ($urandom_range(4) < 3);
         disp_op1_tag   = TW'($urandom_range(7));
         disp_op2_tag   = TW'($urandom_range(7));
         disp_ca_tag    = TW'($urandom_range(7));
         cdb_valid      = ($urandom_range(4) < 2);
         cdb_tag        = TW'($urandom_range(7));
         cdb_data       = $urandom;
         cdb_ca         = 1'($urandom_range(1));
         issue_ready    = ($urandom_range(4) < 3);
         cycle();
         n_checks++;
         if (issue_valid !== m_iv || count !== 3'(q.size()) || disp_ready !== (q.size() < ENTRIES)) begin
            if (errs < 10)
               $display("FAIL rand_ctrl cyc %0d: v=%0b count=%0d rdy=%0b, expected %0b/%0d/%0b",
                        cyc, issue_valid, count, disp_ready, m_iv, q.size(), q.size() < ENTRIES);
            errs++;
         end else n_pass++;
         if (m_iv) begin
            n_checks++;
            if (issue_rs_id !== RW'(m_id) || issue_result_reg_addr !== m_rd || issue_op1 !== m_op1 ||
                issue_op2 !== m_op2 || issue_carry_in !== m_ca || issue_control !== m_ctrl) begin
               if (errs < 10)
                  $display("FAIL rand_payload cyc %0d: id=%0d rd=%0d op1=%h op2=%h ca=%0b ctl=%0h, expected %0d/%0d/%h/%h/%0b/%0h",
                           cyc, issue_rs_id, issue_result_reg_addr, issue_op1, issue_op2, issue_carry_in,
                           issue_control, m_id, m_rd, m_op1, m_op2, m_ca, m_ctrl);
               errs++;
            end else n_pass++;
         end
      end
      rst = 0;
      set_idle();
   endtask

   initial begin
      rst = 1;
      issue_ready = 1;
      set_idle();
      test_reset();
      test_basic();
      test_wakeup();
      test_order();
      test_full();
      test_bypass();
      test_reset_inflight();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
